// File: rtl/if_id_skid_stage_pkg.sv
// Shared definitions for the IF/ID skid stage: state encoding and MIPS defaults.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [31:0] PC_RST_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_DEFAULT    = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch-side and decode-side valid/ready handshake bundle for the IF/ID stage.
interface if_id_skid_stage_if #(
    parameter int unsigned IW = 32,
    parameter int unsigned AW = 32
) ();

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [AW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    // Environment view: drives fetch beats and decode ready
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    // Stage view
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );

endinterface

// File: rtl/if_id_skid_stage_sat_counter.sv
// Saturating event counter, reusable for stage performance counters.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count enabled cycles, sticking at the maximum value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID boundary: 2-entry skid buffer with registered in_ready, flush and stall counter.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned IW        = 32,
    parameter int unsigned AW        = 32,
    parameter logic [31:0] PC_RST    = PC_RST_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    if_id_skid_stage_if.slave   bus,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [AW-1:0] PC_INIT  = AW'(PC_RST);
    localparam logic [IW-1:0] NOP_INIT = IW'(NOP_INSTR);

    skid_state_e   state;
    logic [IW-1:0] main_instr;
    logic [IW-1:0] skid_instr;
    logic [AW-1:0] main_pc;
    logic [AW-1:0] skid_pc;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          accept_c;
    logic          xfer_c;

    assign accept_c = bus.in_valid & in_ready_q;
    assign xfer_c   = out_valid_q & bus.out_ready;

    // Skid FSM and datapath; status outputs are registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_EMPTY;
            main_instr  <= NOP_INIT;
            skid_instr  <= NOP_INIT;
            main_pc     <= PC_INIT;
            skid_pc     <= PC_INIT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy   <= 2'd0;
        end else if (flush) begin
            state       <= S_EMPTY;
            main_instr  <= NOP_INIT;
            skid_instr  <= NOP_INIT;
            main_pc     <= PC_INIT;
            skid_pc     <= PC_INIT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy   <= 2'd0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept_c) begin
                        main_instr  <= bus.in_instr;
                        main_pc     <= bus.in_pc;
                        state       <= S_ONE;
                        out_valid_q <= 1'b1;
                        occupancy   <= 2'd1;
                    end
                end
                S_ONE: begin
                    if (xfer_c && accept_c) begin
                        main_instr <= bus.in_instr;
                        main_pc    <= bus.in_pc;
                    end else if (xfer_c) begin
                        // main data is kept; the output mux masks the instruction
                        state       <= S_EMPTY;
                        out_valid_q <= 1'b0;
                        occupancy   <= 2'd0;
                    end else if (accept_c) begin
                        skid_instr <= bus.in_instr;
                        skid_pc    <= bus.in_pc;
                        state      <= S_FULL;
                        in_ready_q <= 1'b0;
                        occupancy  <= 2'd2;
                    end
                end
                S_FULL: begin
                    if (xfer_c) begin
                        main_instr <= skid_instr;
                        main_pc    <= skid_pc;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                        occupancy  <= 2'd1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    occupancy   <= 2'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_valid_q ? main_instr : NOP_INIT;
    assign bus.out_pc    = main_pc;

    // Cycles where decode stalls a valid beat
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (out_valid_q & ~bus.out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: directed table, corner sequences, random vs queue model.
module tb_if_id_skid_stage;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = 15;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    if_id_skid_stage_if #(.IW(32), .AW(32)) bus ();

    if_id_skid_stage #(
        .IW(32), .AW(32), .PC_RST(32'h0000_3000), .NOP_INSTR(32'h0), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [1:0]  e_occ;
        logic        e_rdy;
        int          e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    vec_t  vecs[14];
    beat_t q[$];
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] pc, input logic [1:0] occ,
                             input logic rdy, input int cnt);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".out_instr"}, bus.out_instr, ins);
        chk({tag, ".out_pc"}, bus.out_pc, pc);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
    endtask

    // Apply one cycle of inputs at the falling edge, return at the next falling edge
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference model: FIFO of held beats (max 2), last shown PC, saturating stall count
    task automatic model_reset();
        q.delete();
        m_pc  = 32'h0000_3000;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                              input logic ordy, input logic fl);
        bit acc;
        bit xf;
        beat_t b;
        acc = iv && (q.size() < 2);
        xf  = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy && (m_cnt < CMAX)) m_cnt++;
        if (fl) begin
            q.delete();
            m_pc = 32'h0000_3000;
        end else begin
            if (xf) begin
                m_pc = q[0].pc;
                void'(q.pop_front());
            end
            if (acc) begin
                b.instr = ins;
                b.pc    = pc;
                q.push_back(b);
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic v;
        v = (q.size() > 0);
        check_all(tag, v, v ? q[0].instr : 32'h0, v ? q[0].pc : m_pc,
                  2'(q.size()), q.size() != 2, m_cnt);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b0;

        //          iv  instr          pc            ordy fl  v  instr         pc            occ rdy cnt
        vecs[0]  = '{1, 32'h24080001, 32'h3000, 1, 0, 1, 32'h24080001, 32'h3000, 1, 1, 0};
        vecs[1]  = '{1, 32'h24090002, 32'h3004, 1, 0, 1, 32'h24090002, 32'h3004, 1, 1, 0};
        vecs[2]  = '{1, 32'h240a0003, 32'h3008, 1, 0, 1, 32'h240a0003, 32'h3008, 1, 1, 0};
        vecs[3]  = '{0, 32'h0,        32'h0,    1, 0, 0, 32'h0,        32'h3008, 0, 1, 0};
        vecs[4]  = '{1, 32'h11110000, 32'h3000, 0, 0, 1, 32'h11110000, 32'h3000, 1, 1, 0};
        vecs[5]  = '{1, 32'h22220000, 32'h3004, 0, 0, 1, 32'h11110000, 32'h3000, 2, 0, 1};
        vecs[6]  = '{1, 32'h33330000, 32'h3008, 0, 0, 1, 32'h11110000, 32'h3000, 2, 0, 2};
        vecs[7]  = '{1, 32'h33330000, 32'h3008, 1, 0, 1, 32'h22220000, 32'h3004, 1, 1, 2};
        vecs[8]  = '{1, 32'h33330000, 32'h3008, 1, 0, 1, 32'h33330000, 32'h3008, 1, 1, 2};
        vecs[9]  = '{0, 32'h0,        32'h0,    1, 0, 0, 32'h0,        32'h3008, 0, 1, 2};
        vecs[10] = '{1, 32'haaaa0000, 32'h3010, 0, 0, 1, 32'haaaa0000, 32'h3010, 1, 1, 2};
        vecs[11] = '{1, 32'hbbbb0000, 32'h3014, 0, 0, 1, 32'haaaa0000, 32'h3010, 2, 0, 3};
        vecs[12] = '{1, 32'hcccc0000, 32'h3018, 0, 1, 0, 32'h0,        32'h3000, 0, 1, 4};
        vecs[13] = '{0, 32'h0,        32'h0,    1, 0, 0, 32'h0,        32'h3000, 0, 1, 4};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_all("rst", 1'b0, 32'h0, 32'h3000, 2'd0, 1'b1, 0);
        reset = 1'b1;

        // Directed table: first beat latency, streaming, stall/skid, flush in FULL
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            check_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_instr, vecs[i].e_pc,
                      vecs[i].e_occ, vecs[i].e_rdy, vecs[i].e_cnt);
        end

        // Counter saturation, hold through flush, clear by reset
        reset_pulse();
        chk("sat.cleared", 32'(stall_cnt), 32'd0);
        drive(1'b1, 32'h5555_0000, 32'h3000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat.max", 32'(stall_cnt), 32'd15);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat.hold", 32'(stall_cnt), 32'd15);
        drive(1'b1, 32'h6666_0000, 32'h3100, 1'b0, 1'b1);
        check_all("sat.flush", 1'b0, 32'h0, 32'h3000, 2'd0, 1'b1, 15);

        // Async reset while FULL, checked before the next rising edge
        drive(1'b1, 32'h7777_0000, 32'h3200, 1'b0, 1'b0);
        drive(1'b1, 32'h8888_0000, 32'h3204, 1'b0, 1'b0);
        chk("full.occ", 32'(occupancy), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 32'h0, 32'h3000, 2'd0, 1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h9999_0000, 32'h4000, 1'b1, 1'b0);
        check_all("post_rst", 1'b1, 32'h9999_0000, 32'h4000, 2'd1, 1'b1, 0);

        // Random traffic against the queue model
        reset_pulse();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic iv, ordy, fl;
            logic [31:0] ins, pc;
            model_check($sformatf("rnd%0d", c));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            ins  = $urandom;
            pc   = $urandom;
            model_step(iv, ins, pc, ordy, fl);
            drive(iv, ins, pc, ordy, fl);
        end
        model_check("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline boundary register. It replaces the single-register, stall-only stage with a 2-entry skid buffer and a valid/ready handshake on both sides.
- It carries instruction and PC fields of configurable width and supports synchronous flush for branch/jump squash.
- It masks bubbles to a NOP and keeps a saturating backpressure counter.
- It sits between instruction fetch and decode and breaks the combinational ready path from decode back to fetch.

Parameters:
- IW, 32, instruction field width
- AW, 32, PC field width
- PC_RST, 32'h00003000, PC value loaded on reset and on flush (truncated to AW)
- NOP_INSTR, 32'h0, instruction presented while out_valid=0 (truncated to IW)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage can accept a beat; registered
- in_instr  in  IW  fetched instruction
- in_pc  in  AW  PC of fetched instruction
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts the beat; 0 means stall
- out_instr  out  IW  instruction to decode
- out_pc  out  AW  PC to decode
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clocking and reset: one clock domain. reset is asynchronous and active-low; its assertion takes effect immediately without a clock edge.
- Reset values:
  - state EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0
  - main and skid PC registers = PC_RST; instr registers = NOP_INSTR
- Handshake rules:
  - Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = (state != FULL), derived from registered state only; it never depends combinationally on out_ready.
- Latency: 1 cycle from accept to out_valid when EMPTY.
- out_instr = NOP_INSTR whenever out_valid=0; otherwise the main-register instruction. out_pc always shows the main-register PC.
- States: EMPTY (occupancy 0), ONE (main valid, occupancy 1), FULL (main and skid valid, occupancy 2).
- Transitions when flush=0:
  - EMPTY: accept -> main<=in, ONE; otherwise stay.
  - ONE, transfer and accept -> main<=in, stay ONE.
  - ONE, transfer and no accept -> EMPTY; main data is retained, instr masked.
  - ONE, no transfer and accept -> skid<=in, FULL.
  - ONE, neither -> hold.
  - FULL: transfer -> main<=skid, ONE. No input is accepted (in_ready=0). No transfer -> hold.
- Ordering: beats leave in arrival order. The skid entry is never overtaken.
- Flush (synchronous, highest priority):
  - Next state EMPTY. Both PC registers <= PC_RST; both instr registers <= NOP_INSTR.
  - A beat accepted in the flush cycle is discarded.
  - A transfer in the flush cycle still counts as delivered to decode; decode squashes it itself.
  - stall_cnt is not affected by flush.
- stall_cnt:
  - Increments by 1 each cycle where out_valid=1 and out_ready=0, flush included.
  - Saturates at 2^CNT_W-1 and never wraps. Cleared only by reset.
- Reset mid-operation: all held entries are lost immediately and outputs go to reset values. The first accept after reset release lands in main.
- No X on outputs after reset; data registers always hold defined values.

Decomposition:
- Shared package (pipe_pkg): state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2, and the MIPS default constants PC_RST_DEFAULT=32'h00003000 and NOP_DEFAULT=32'h0.
- One natural sub-module: sat_counter (CNT_W, increment enable, async active-low reset, saturate at max). It is reusable for other stage performance counters.
- The skid datapath and FSM stay in the top module.

Test Plan:
1. Reset release, in_valid=1 with instr=32'h24080001 and pc=32'h3000, out_ready=1 -> one cycle later out_valid=1, out_instr=32'h24080001, out_pc=32'h3000, occupancy=1.
2. Streaming: pcs 0x3000, 0x3004, 0x3008 back to back with out_ready=1 -> same order out, one per cycle, in_ready stays 1, occupancy never reaches 2.
3. Stall: hold out_ready=0 while sending 0x3000 then 0x3004 -> occupancy=2 and in_ready=0 from the next cycle. A third beat 0x3008 is held off. After out_ready=1, outputs are 0x3000 then 0x3004 then 0x3008; no loss or duplication.
4. Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_instr=32'h0, out_pc=32'h3000, occupancy=0, in_ready=1; the flush-cycle input beat never appears.
5. Counter saturation with CNT_W=4 and 20 stall cycles -> stall_cnt=15 and holds 15. Flush leaves it at 15. Reset returns it to 0.
6. Async reset asserted mid-clock while FULL -> outputs go to reset values before the next clk edge. The first beat after release appears with 1-cycle latency.
